// File: rtl/azimuth_pkg.sv
// Shared constants, types and helpers for the azimuth pattern path
// (frame loader, signal generator and their marker synchronizers).
package azimuth_pkg;

    localparam int WORD_W          = 32;
    localparam int AZ_SIZE_DEFAULT = 3200;

    typedef enum logic {
        AZL_FILL = 1'b0,
        AZL_FULL = 1'b1
    } az_state_t;

    function automatic int az_words(input int size);
        return size / WORD_W;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer plus an edge flop for an asynchronous marker input;
// evt is high for one CLK cycle per synchronized rising edge.
module sync_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic evt
);

    logic r_sync1;
    logic r_sync2;
    logic r_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    assign evt = r_sync2 & ~r_dly;

endmodule

// File: rtl/azimuth_frame_loader.sv
// Assembles an AXI-Stream azimuth frame into a shadow buffer and swaps it into
// DATA on each ARP revolution marker, followed one cycle later by a TRIG pulse.
//
// Stream handshake: a word transfers on a rising CLK edge where S_TVALID and
// S_TREADY are both high. S_TREADY is registered and only high in FILL with EN.
module azimuth_frame_loader
    import azimuth_pkg::*;
#(
    parameter  int SIZE   = AZ_SIZE_DEFAULT,
    localparam int NW     = az_words(SIZE),
    localparam int WCNT_W = ($clog2(NW) > 7) ? $clog2(NW) : 7
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              ARP_IN,
    input  logic [WORD_W-1:0] S_TDATA,
    input  logic              S_TVALID,
    input  logic              S_TLAST,
    output logic              S_TREADY,
    output logic [SIZE-1:0]   DATA,
    output logic              TRIG,
    output logic              LOADED,
    output logic              ERR,
    output logic [15:0]       UNDERRUN,
    output az_state_t         DBG_STATE,
    output logic [WCNT_W-1:0] DBG_WCNT
);

    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(NW - 1);

    generate
        if (SIZE % WORD_W != 0) begin : g_size_check
            $error("azimuth_frame_loader: SIZE must be a multiple of WORD_W");
        end
    endgenerate

    az_state_t         r_state;
    az_state_t         w_state_nxt;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_nxt;
    logic [SIZE-1:0]   r_shadow;
    logic [SIZE-1:0]   r_data;
    logic              r_tready;
    logic              r_trig_pend;
    logic              r_trig;
    logic              r_loaded;
    logic              r_err;
    logic [15:0]       r_underrun;

    logic              w_arp_evt;
    logic              w_accept;
    logic              w_load;
    logic              w_err_set;
    logic              w_swap;
    logic              w_under_inc;
    logic              w_trig_sched;

    sync_rise_detect u_arp_sync (
        .clk      (CLK),
        .rst_n    (RST_N),
        .async_in (ARP_IN),
        .evt      (w_arp_evt)
    );

    assign w_accept = S_TVALID && r_tready;
    assign w_load   = w_accept && EN && (r_state == AZL_FILL);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= AZL_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A last word accepted together with an ARP event still moves to FULL;
    // the event is charged as an underrun and the new frame waits one revolution.
    always_comb begin
        w_state_nxt  = r_state;
        w_wcnt_nxt   = r_wcnt;
        w_err_set    = 1'b0;
        w_swap       = 1'b0;
        w_under_inc  = 1'b0;
        w_trig_sched = 1'b0;
        if (!EN) begin
            w_wcnt_nxt = '0;
        end else begin
            case (r_state)
                AZL_FILL: begin
                    if (w_load) begin
                        if (r_wcnt == LAST_IDX) begin
                            w_state_nxt = AZL_FULL;
                            w_wcnt_nxt  = '0;
                            w_err_set   = !S_TLAST;
                        end else if (S_TLAST) begin
                            w_wcnt_nxt = '0;
                            w_err_set  = 1'b1;
                        end else begin
                            w_wcnt_nxt = r_wcnt + 1'b1;
                        end
                    end
                    if (w_arp_evt) begin
                        w_under_inc  = 1'b1;
                        w_trig_sched = r_loaded;
                    end
                end
                AZL_FULL: begin
                    if (w_arp_evt) begin
                        w_swap       = 1'b1;
                        w_state_nxt  = AZL_FILL;
                        w_trig_sched = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = AZL_FILL;
                    w_wcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wcnt      <= '0;
            r_tready    <= 1'b0;
            r_data      <= '0;
            r_trig_pend <= 1'b0;
            r_trig      <= 1'b0;
            r_loaded    <= 1'b0;
            r_err       <= 1'b0;
            r_underrun  <= '0;
        end else begin
            r_wcnt      <= w_wcnt_nxt;
            r_tready    <= EN && (w_state_nxt == AZL_FILL);
            r_trig_pend <= w_trig_sched;
            r_trig      <= r_trig_pend;
            if (w_swap) begin
                r_data   <= r_shadow;
                r_loaded <= 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_under_inc && (r_underrun != 16'hFFFF)) begin
                r_underrun <= r_underrun + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shadow <= '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (w_load && (r_wcnt == WCNT_W'(k))) begin
                    r_shadow[k*WORD_W +: WORD_W] <= S_TDATA;
                end
            end
        end
    end

    assign S_TREADY  = r_tready;
    assign DATA      = r_data;
    assign TRIG      = r_trig;
    assign LOADED    = r_loaded;
    assign ERR       = r_err;
    assign UNDERRUN  = r_underrun;
    assign DBG_STATE = r_state;
    assign DBG_WCNT  = r_wcnt;

endmodule
